// File: rtl/mem_stage.sv
// mem_stage: load/store unit front end. It takes one memory access at a time
// from the pipeline and drives a simple req/ack bus. Loads return data shifted
// down to bit 0 for the writeback stage. Misaligned or malformed requests are
// refused without touching the bus. A request with no ack is aborted after
// TIMEOUT wait cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] dmem_data_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        launch, capture, req_ok;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] lane_wdata_q;
  logic [31:0] dmem_q;

  // Half needs an even address, word needs a 4-byte aligned one.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow datum puts it on every lane, which is the same as
  // shifting it left by 8*a within the lanes that are enabled.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {a, 3'b000};
    case (size)
      2'b00:   return {24'h0, shifted[7:0]};
      2'b01:   return {16'h0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  assign req_ok = (mem_read_i ^ mem_write_i) && is_aligned(size_i, addr_i[1:0]);

  // Next-state, wait-counter and datapath-enable decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    launch       = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          if (req_ok) begin
            state_nxt    = ACCESS;
            wait_cnt_nxt = 8'd0;
            launch       = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ACCESS: begin
        // An ack in the final wait cycle still completes the access.
        if (bus_ack_i) begin
          state_nxt = RESP;
          capture   = ~we_q;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Access latch on launch, load result capture on ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      lane_wdata_q <= 32'h0;
      dmem_q       <= 32'h0;
    end else begin
      if (launch) begin
        addr_q       <= addr_i;
        size_q       <= size_i;
        we_q         <= mem_write_i;
        be_q         <= byte_enables(size_i, addr_i[1:0]);
        lane_wdata_q <= lane_data(size_i, wdata_i);
      end
      if (capture) begin
        dmem_q <= load_extract(size_q, addr_q[1:0], bus_rdata_i);
      end
    end
  end

  // The bus is only driven while an access is outstanding.
  assign bus_req_o   = (state == ACCESS);
  assign bus_we_o    = bus_req_o & we_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be_o    = bus_req_o ? be_q : 4'h0;
  assign bus_wdata_o = bus_req_o ? lane_wdata_q : 32'h0;

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == RESP) || (state == ERR);
  assign err_o       = (state == ERR);
  assign dmem_data_o = dmem_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, refused requests, timeout,
// ack-on-last-wait-cycle and reset during an access.
module tb_mem_stage;

  logic        clk;
  logic        rst_ni;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] dmem_data_o;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .size_i      (size_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .dmem_data_o (dmem_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, " req"},   32'(bus_req_o),   32'h0);
    check({tag, " we"},    32'(bus_we_o),    32'h0);
    check({tag, " addr"},  bus_addr_o,       32'h0);
    check({tag, " be"},    32'(bus_be_o),    32'h0);
    check({tag, " wdata"}, bus_wdata_o,      32'h0);
    check({tag, " busy"},  32'(busy_o),      32'h0);
    check({tag, " done"},  32'(done_o),      32'h0);
    check({tag, " err"},   32'(err_o),       32'h0);
    check({tag, " dmem"},  dmem_data_o,      32'h0);
  endtask

  task automatic request(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    size_i = sz; addr_i = a; wdata_i = wd;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    size_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b1;
    idle_inputs();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1 rst_ni = 1'b0;
    #1 all_zero("reset");
    tick(); tick();
    @(negedge clk) rst_ni = 1'b1;
    tick();

    // Load byte at 0x1003, ack after two wait cycles.
    request(1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0);
    tick();
    idle_inputs();
    check("lb req",   32'(bus_req_o),  32'h1);
    check("lb we",    32'(bus_we_o),   32'h0);
    check("lb addr",  bus_addr_o,      32'h0000_1000);
    check("lb be",    32'(bus_be_o),   32'h8);
    check("lb busy",  32'(busy_o),     32'h1);
    tick();
    check("lb be w1", 32'(bus_be_o),   32'h8);
    tick();
    check("lb req w2", 32'(bus_req_o), 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAABB_CCDD;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("lb done",  32'(done_o),     32'h1);
    check("lb err",   32'(err_o),      32'h0);
    check("lb dmem",  dmem_data_o,     32'h0000_00AA);
    check("lb req off", 32'(bus_req_o), 32'h0);
    tick();
    check("lb idle busy", 32'(busy_o), 32'h0);
    check("lb idle done", 32'(done_o), 32'h0);

    // Store half at 0x2002, zero-wait ack; load result must not move.
    request(1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234);
    tick();
    idle_inputs();
    check("sh we",    32'(bus_we_o),   32'h1);
    check("sh be",    32'(bus_be_o),   32'hC);
    check("sh addr",  bus_addr_o,      32'h0000_2000);
    check("sh lane",  {16'h0, bus_wdata_o[31:16]}, 32'h0000_1234);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    check("sh done",  32'(done_o),     32'h1);
    check("sh err",   32'(err_o),      32'h0);
    check("sh dmem",  dmem_data_o,     32'h0000_00AA);
    tick();

    // Store byte at 0x3001.
    request(1'b0, 1'b1, 2'b00, 32'h0000_3001, 32'h0000_00A5);
    tick();
    idle_inputs();
    check("sb be",    32'(bus_be_o),   32'h2);
    check("sb lane",  {24'h0, bus_wdata_o[15:8]}, 32'h0000_00A5);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    check("sb done",  32'(done_o),     32'h1);
    tick();

    // Misaligned load word: refused, no bus activity.
    request(1'b1, 1'b0, 2'b10, 32'h0000_0001, 32'h0);
    tick();
    idle_inputs();
    check("mis req",  32'(bus_req_o),  32'h0);
    check("mis done", 32'(done_o),     32'h1);
    check("mis err",  32'(err_o),      32'h1);
    tick();
    check("mis idle", 32'(busy_o),     32'h0);
    check("mis dmem", dmem_data_o,     32'h0000_00AA);

    // Both strobes set, then illegal size.
    request(1'b1, 1'b1, 2'b00, 32'h0000_0000, 32'h0);
    tick();
    idle_inputs();
    check("both err", 32'(err_o),      32'h1);
    check("both req", 32'(bus_req_o),  32'h0);
    tick();
    request(1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'h0);
    tick();
    idle_inputs();
    check("sz11 err", 32'(err_o),      32'h1);
    tick();

    // No ack: request held exactly TIMEOUT cycles, then error; late ack ignored.
    request(1'b1, 1'b0, 2'b10, 32'h0000_0008, 32'h0);
    tick();
    idle_inputs();
    n = 0;
    while (bus_req_o && n < 40) begin
      n++;
      tick();
    end
    check("to cycles", 32'(n),         32'd15);
    check("to err",   32'(err_o),      32'h1);
    check("to done",  32'(done_o),     32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    tick();
    check("late idle", 32'(busy_o),    32'h0);
    check("late done", 32'(done_o),    32'h0);
    tick();
    bus_ack_i = 1'b0;
    check("late dmem", dmem_data_o,    32'h0000_00AA);
    check("late busy", 32'(busy_o),    32'h0);

    // Ack in the last wait cycle wins over the timeout.
    request(1'b1, 1'b0, 2'b01, 32'h0000_0006, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    check("edge req", 32'(bus_req_o),  32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0000;
    tick();
    bus_ack_i = 1'b0;
    check("edge done", 32'(done_o),    32'h1);
    check("edge err", 32'(err_o),      32'h0);
    check("edge dmem", dmem_data_o,    32'h0000_CAFE);
    tick();

    // Reset during an access.
    request(1'b1, 1'b0, 2'b10, 32'h0000_0004, 32'h0);
    tick();
    idle_inputs();
    check("rst pre req", 32'(bus_req_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1 all_zero("rst mid");
    tick();
    check("rst no done", 32'(done_o),  32'h0);
    @(negedge clk) rst_ni = 1'b1;
    tick();
    check("rst resume idle", 32'(busy_o), 32'h0);
    request(1'b1, 1'b0, 2'b10, 32'h0000_0004, 32'h0);
    tick();
    idle_inputs();
    check("lw addr",  bus_addr_o,      32'h0000_0004);
    check("lw be",    32'(bus_be_o),   32'hF);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    tick();
    bus_ack_i = 1'b0;
    check("lw done",  32'(done_o),     32'h1);
    check("lw dmem",  dmem_data_o,     32'h1234_5678);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent waiting for bus_ack_i before the access is aborted (legal range 1..255).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port valid_i, input, 1 bit: access request; sampled only in IDLE.
REQ-005 The block SHALL have port mem_read_i, input, 1 bit: load access.
REQ-006 The block SHALL have port mem_write_i, input, 1 bit: store access.
REQ-007 The block SHALL have port size_i, input, 2 bits: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 The block SHALL have port addr_i, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata_i, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port bus_req_o, output, 1 bit: bus request.
REQ-011 The block SHALL have port bus_we_o, output, 1 bit: 1 means write.
REQ-012 The block SHALL have port bus_addr_o, output, 32 bits: word-aligned address, {addr[31:2],2'b00}.
REQ-013 The block SHALL have port bus_be_o, output, 4 bits: byte enables.
REQ-014 The block SHALL have port bus_wdata_o, output, 32 bits: lane-shifted store data.
REQ-015 The block SHALL have port bus_ack_i, input, 1 bit: transfer complete; bus_rdata_i is valid in the same cycle.
REQ-016 The block SHALL have port bus_rdata_i, input, 32 bits: read word.
REQ-017 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-018 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-019 The block SHALL have port err_o, output, 1 bit: one-cycle error pulse, coincident with done_o.
REQ-020 The block SHALL have port dmem_data_o, output, 32 bits: load data shifted down to bit 0, with unused upper bits zero; this port feeds the writeback stage, which performs sign/zero extension.

Function
REQ-021 The FSM SHALL have exactly four states, IDLE, ACCESS, RESP and ERR, with ERR also reachable from ACCESS on timeout (REQ-026).
REQ-022 In IDLE, valid_i with exactly one of mem_read_i/mem_write_i, a legal size and an aligned address SHALL latch addr, size, direction and wdata, then go to ACCESS.
- Aligned means: half requires addr[0]=0; word requires addr[1:0]=00.
REQ-023 In IDLE, valid_i with a misaligned address, size 11, or both/neither of the read/write strobes SHALL go to ERR with no bus request.
REQ-024 In ACCESS, bus_req_o SHALL be 1 and bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o SHALL be held stable until the cycle bus_ack_i=1.
- Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
- bus_wdata_o = wdata shifted left by 8*a[1:0], with byte/half replicated to the enabled lanes.
REQ-025 On bus_ack_i in ACCESS, the block SHALL register dmem_data_o for loads only, as bus_rdata_i>>(8*a[1:0]) masked to the access size, then go to RESP.
REQ-026 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
- When it reaches TIMEOUT without an ack, the block SHALL drop bus_req_o and go to ERR.
- If ack arrives in the same cycle the timeout expires, the ack SHALL win.
REQ-027 RESP SHALL last one cycle with done_o=1 and err_o=0, then return to IDLE; best case is 3 cycles from valid_i to done_o with a zero-wait ack.
REQ-028 ERR SHALL last one cycle with done_o=1 and err_o=1, then return to IDLE; dmem_data_o SHALL be unchanged by ERR.
REQ-029 Outside IDLE, valid_i SHALL be ignored; bus_ack_i in any state other than ACCESS SHALL be ignored.
REQ-030 dmem_data_o SHALL hold its value until the next successful load completes; stores SHALL NOT modify it.

Reset
REQ-031 With rst_ni=0, all of the following SHALL be forced immediately, independent of clk_i:
- state to IDLE, wait counter to 0;
- bus_req_o, bus_we_o, busy_o, done_o and err_o to 0;
- bus_addr_o, bus_be_o, bus_wdata_o and dmem_data_o to 0.
REQ-032 Reset asserted mid-access SHALL abandon the access with no done_o pulse; operation SHALL resume in IDLE on the first clock after rst_ni rises.

Verification
REQ-033 Load byte: addr=0x1003, size=00, ack after 2 wait cycles, rdata=0xAABBCCDD -> bus_be_o=1000, bus_addr_o=0x1000, dmem_data_o=0x000000AA, done_o pulse, err_o=0.
REQ-034 Store half: addr=0x2002, wdata=0x00001234, zero-wait ack -> bus_we_o=1, bus_be_o=1100, bus_wdata_o[31:16]=0x1234, done_o pulse, dmem_data_o unchanged.
REQ-035 Misaligned load word at addr=0x0001 -> no bus_req_o, done_o=err_o=1 in the second cycle, back to IDLE.
REQ-036 Load with no ack, TIMEOUT=15 -> bus_req_o high for exactly 15 cycles, then err_o pulse; a late ack is ignored.
REQ-037 rst_ni pulled low during ACCESS -> all outputs are 0 immediately; no done_o; a following load word at 0x4 with rdata=0x12345678 gives dmem_data_o=0x12345678.
